// File: rtl/out_wrapper_pkg.sv
// Shared definitions for the FP-core output wrapper: data/buffer sizing and
// the control FSM state encoding.
package out_wrapper_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int PTR_W  = 1;   // log2(DEPTH); pointers wrap naturally modulo 2
    localparam int CNT_W  = 2;   // holds 0..DEPTH

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage : out_wrapper_pkg

// File: rtl/out_fifo2.sv
// Two-entry result FIFO. Holds storage, read/write pointers, occupancy and
// the sticky overflow flag. A push while full is dropped and flagged.
module out_fifo2
    import out_wrapper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok;
    logic              pop_ok;

    // Next-state for storage, pointers, count and overflow. Whether a push
    // fits is decided from the registered count only, so a pop on the same
    // edge never makes room for a result that arrived while full.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        push_ok = push && (count_q < CNT_W'(DEPTH));
        pop_ok  = pop && (count_q != '0);

        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign rdata    = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule : out_fifo2

// File: rtl/out_wrapper.sv
// Buffers FP-core results and hands them to a consumer over a 4-phase
// request/acknowledge handshake.
//
// Handshake: outReady=1 means outBus holds a valid result and stays stable
// until the consumer raises outAccepted. The entry is consumed on the edge
// where outReady=1 and outAccepted=1; outReady then drops and no new entry
// is offered until outAccepted has returned low.
module out_wrapper
    import out_wrapper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [DATA_W-1:0] result,
    output logic              resultReady,
    output logic [DATA_W-1:0] outBus,
    output logic              outReady,
    input  logic              outAccepted,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    state_e            state_q, state_d;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    out_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (done),
        .wdata    (result),
        .pop      (fifo_pop),
        .rdata    (fifo_head),
        .count    (fifo_count),
        .overflow (overflow)
    );

    // FSM next state and outputs. The head is shown only in PRESENT; pushes
    // land in the other slot, so outBus cannot change while presenting.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        outReady = 1'b0;
        outBus   = '0;

        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                outReady = 1'b1;
                outBus   = fifo_head;
                if (outAccepted) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!outAccepted) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register with asynchronous return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign count       = fifo_count;
    assign resultReady = (fifo_count < CNT_W'(DEPTH));

endmodule : out_wrapper

// File: tb/tb_out_wrapper.sv
// Directed bench for out_wrapper: single transfer, back-to-back, overflow,
// concurrent push/pop, held acknowledge, idle acknowledge, mid-transfer reset.
module tb_out_wrapper;

    logic        clk;
    logic        rst;
    logic        done;
    logic [31:0] result;
    logic        resultReady;
    logic [31:0] outBus;
    logic        outReady;
    logic        outAccepted;
    logic [1:0]  count;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    out_wrapper dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .result      (result),
        .resultReady (resultReady),
        .outBus      (outBus),
        .outReady    (outReady),
        .outAccepted (outAccepted),
        .count       (count),
        .overflow    (overflow)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single push: drive done for one edge.
    task automatic push_one(input logic [31:0] val);
        done   = 1'b1;
        result = val;
        tick();
        done   = 1'b0;
        result = '0;
    endtask

    initial begin
        rst         = 1'b1;
        done        = 1'b0;
        result      = '0;
        outAccepted = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("rst_outReady", 32'(outReady), 32'd0);
        check("rst_outBus", outBus, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_resultReady", 32'(resultReady), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- Single transfer ----------------
        push_one(32'h3F80_0000);                    // E0
        check("single_count_after_E0", 32'(count), 32'd1);
        check("single_outReady_after_E0", 32'(outReady), 32'd0);
        tick();                                     // E1
        check("single_outReady_after_E1", 32'(outReady), 32'd1);
        check("single_outBus", outBus, 32'h3F80_0000);
        outAccepted = 1'b1;
        tick();
        check("single_release_outReady", 32'(outReady), 32'd0);
        check("single_release_outBus", outBus, 32'h0);
        check("single_release_count", 32'(count), 32'd0);
        outAccepted = 1'b0;
        tick();
        tick();
        check("single_idle_outReady", 32'(outReady), 32'd0);
        check("single_idle_count", 32'(count), 32'd0);

        // ---------------- Back-to-back ----------------
        push_one(32'h4000_0000);
        check("b2b_count1", 32'(count), 32'd1);
        push_one(32'hC049_0FDB);
        check("b2b_count2", 32'(count), 32'd2);
        check("b2b_resultReady", 32'(resultReady), 32'd0);
        check("b2b_first_outReady", 32'(outReady), 32'd1);
        check("b2b_first_outBus", outBus, 32'h4000_0000);
        outAccepted = 1'b1;
        tick();
        check("b2b_after_pop_count", 32'(count), 32'd1);
        check("b2b_after_pop_outReady", 32'(outReady), 32'd0);
        outAccepted = 1'b0;
        tick();
        tick();
        check("b2b_second_outReady", 32'(outReady), 32'd1);
        check("b2b_second_outBus", outBus, 32'hC049_0FDB);
        outAccepted = 1'b1;
        tick();
        outAccepted = 1'b0;
        tick();
        check("b2b_drained_count", 32'(count), 32'd0);

        // ---------------- Overflow ----------------
        push_one(32'h1234_5678);
        push_one(32'h9ABC_DEF0);
        check("ovf_full_count", 32'(count), 32'd2);
        check("ovf_before_flag", 32'(overflow), 32'd0);
        push_one(32'h7FC0_0000);
        check("ovf_flag_set", 32'(overflow), 32'd1);
        check("ovf_count_stays", 32'(count), 32'd2);
        check("ovf_outBus_stable", outBus, 32'h1234_5678);
        outAccepted = 1'b1;
        tick();
        outAccepted = 1'b0;
        tick();
        tick();
        check("ovf_second_entry", outBus, 32'h9ABC_DEF0);
        outAccepted = 1'b1;
        tick();
        outAccepted = 1'b0;
        tick();
        tick();
        tick();
        check("ovf_no_third_outReady", 32'(outReady), 32'd0);
        check("ovf_drained_count", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // ---------------- Concurrent push/pop ----------------
        push_one(32'h4120_0000);
        tick();
        check("conc_present_outBus", outBus, 32'h4120_0000);
        check("conc_present_count", 32'(count), 32'd1);
        done        = 1'b1;
        result      = 32'h3F00_0000;
        outAccepted = 1'b1;
        tick();
        done        = 1'b0;
        result      = '0;
        check("conc_count_unchanged", 32'(count), 32'd1);
        check("conc_release_outReady", 32'(outReady), 32'd0);
        outAccepted = 1'b0;
        tick();
        tick();
        check("conc_next_outReady", 32'(outReady), 32'd1);
        check("conc_next_outBus", outBus, 32'h3F00_0000);

        // ---------------- Held acknowledge ----------------
        // Push while presenting: outBus must not move.
        push_one(32'h4228_0000);
        check("held_push_outBus_stable", outBus, 32'h3F00_0000);
        check("held_count2", 32'(count), 32'd2);
        outAccepted = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("held_outReady_c%0d", i), 32'(outReady), 32'd0);
            check($sformatf("held_count_c%0d", i), 32'(count), 32'd1);
        end
        outAccepted = 1'b0;
        tick();
        check("held_idle_outReady", 32'(outReady), 32'd0);
        tick();
        check("held_next_outReady", 32'(outReady), 32'd1);
        check("held_next_outBus", outBus, 32'h4228_0000);
        outAccepted = 1'b1;
        tick();
        outAccepted = 1'b0;
        tick();
        check("held_drained_count", 32'(count), 32'd0);

        // ---------------- Acknowledge in IDLE is ignored ----------------
        outAccepted = 1'b1;
        tick();
        tick();
        tick();
        check("idle_ack_outReady", 32'(outReady), 32'd0);
        check("idle_ack_count", 32'(count), 32'd0);
        outAccepted = 1'b0;
        tick();

        // ---------------- Reset mid-PRESENT ----------------
        push_one(32'h1111_1111);
        push_one(32'h2222_2222);
        check("rstmid_outReady_before", 32'(outReady), 32'd1);
        check("rstmid_overflow_before", 32'(overflow), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_outReady_async", 32'(outReady), 32'd0);
        check("rstmid_count_async", 32'(count), 32'd0);
        check("rstmid_overflow_async", 32'(overflow), 32'd0);
        check("rstmid_outBus_async", outBus, 32'h0);
        check("rstmid_resultReady_async", 32'(resultReady), 32'd1);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rstmid_no_deliver_c%0d", i), 32'(outReady), 32'd0);
        end
        check("rstmid_final_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_out_wrapper
